lsu_sequencer: RTL and testbench
================================

# lsu_sequencer

Load/store request sequencer between the core execute stage and `mem_interface`. Accepts one memory request at a time over a valid/ready handshake and holds it stable while driving `mem_interface`. Waits for bus grant, completion or misalignment, and returns a single registered response (load data or error) over a second valid/ready handshake. Also provides flush and a bus-grant timeout.

## Interface
- `DATA_WIDTH`, 32: data width; matches `mem_interface` data.
- `ADDR_WIDTH`, 32: byte address width.
- `SIZE_WIDTH`, 3: sign_size width; bit [SIZE_WIDTH-1] = zero-extend, lower bits = log2(bytes).
- `TIMEOUT_CYCLES`, 255: consecutive no-grant cycles in ISSUE before a timeout error; 0 disables timeout.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high with `req_valid`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_address` in ADDR_WIDTH: byte address.
- `req_sign_size` in SIZE_WIDTH: size/sign code.
- `req_wdata` in DATA_WIDTH: store data, LSB-aligned.
- `flush` in 1: abort the outstanding request.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATA_WIDTH: extended load data; 0 for stores and errors.
- `rsp_error` out 2: 00 ok, 01 misaligned, 10 timeout.
- `mem_available` in 1: bus grant, the same signal seen by `mem_interface`.
- `mem_address` out ADDR_WIDTH, `mem_sign_size` out SIZE_WIDTH, `mem_data_in` out DATA_WIDTH: latched request fields.
- `mem_rd` out 1, `mem_wr` out 1: access strobes.
- `mem_data_out` in DATA_WIDTH: load data, valid only while `mem_complete_read`.
- `mem_malign` in 1, `mem_complete_read` in 1, `mem_complete_write` in 1: status from `mem_interface`.

## Operation
- States: IDLE, ISSUE, WAIT, DROP, RESP.
- Request registers `op_write`, `op_addr`, `op_size`, `op_wdata` load on accept and drive `mem_address`, `mem_sign_size` and `mem_data_in` continuously.
- `req_ready` = !rst && !flush && (IDLE || (RESP && rsp_ready)).
- IDLE: accept goes to ISSUE.
- ISSUE: `mem_rd` = !op_write, `mem_wr` = op_write. Exits are evaluated in priority order:
  - `flush`: go to IDLE, no response.
  - `mem_malign`: go to RESP with error 01.
  - Store with `mem_complete_write`: go to RESP with error 00.
  - Load with `mem_available`: go to WAIT. The load has been issued, and `mem_rd` drops next cycle so there is exactly one bus read per request.
  - Timeout count reaches TIMEOUT_CYCLES: go to RESP with error 10.
- ISSUE timeout counter: cleared on entering ISSUE, increments on each ISSUE cycle with !mem_available, saturating. Width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- WAIT: on `mem_complete_read`, capture `mem_data_out` into `rsp_rdata` with error 00 and go to RESP. If `flush` arrives first, go to DROP.
- DROP: wait for `mem_complete_read`, discard the data, go to IDLE. `req_ready` = 0 in DROP.
- RESP: `rsp_valid` = 1 and `rsp_rdata`/`rsp_error` are held stable.
  - On `rsp_ready`: go to IDLE, or directly to ISSUE if a new request is accepted the same cycle.
  - `flush` in RESP: drop the response, go to IDLE, no accept that cycle.
- `mem_rd`/`mem_wr` are 0 in every state except ISSUE.
- Reset (any state, mid-transaction included): state IDLE; counter, `rsp_rdata` and `rsp_error` cleared to 0. While `rst` is high: `req_ready`, `rsp_valid`, `mem_rd` and `mem_wr` are 0. A read in flight at reset is ignored.

## Timing
- Accepted at cycle 0 with `mem_available` held high and no misalignment:
  - Load: ISSUE at cycle 1, WAIT at cycle 2 (complete_read), `rsp_valid` at cycle 3.
  - Store: ISSUE at cycle 1 (complete_write), `rsp_valid` at cycle 2.
- Misaligned request: `rsp_valid` 2 cycles after accept, and no strobe reaches the bus.
- Timeout with TIMEOUT_CYCLES = N: `rsp_valid` N+1 cycles after entering ISSUE.
- Throughput with `rsp_ready` held high: one store per 2 cycles, one load per 3 cycles.
- All outputs are registered or decoded from state only, except `req_ready`, which is combinational from `rsp_ready` and `flush`.

## Test plan
- Load word at 0x100, size 010, bus returns 0x8000_00F0 -> exactly one `mem_rd` cycle; rsp_rdata 0x8000_00F0 and rsp_error 00 at cycle 3.
- Store word at 0x104 with wdata 0xDEADBEEF -> `mem_wr` for one cycle with mem_data_in 0xDEADBEEF; rsp_error 00 at cycle 2.
- Load halfword at 0x101 with mem_malign=1 -> no `mem_rd` while available; rsp_error 01, rsp_rdata 0.
- TIMEOUT_CYCLES=4, mem_available held 0 -> rsp_error 10 five cycles after entering ISSUE; `mem_rd` then drops.
- Load issued, then flush in WAIT -> DROP; complete_read consumed; no rsp_valid; next request accepted afterwards.
- rsp_ready held 0 for 5 cycles, then pulsed with req_valid high -> response held stable; new request accepted in the same cycle and ISSUE entered the next cycle.

Source files
------------

// File: rtl/lsu_sequencer.sv
// lsu_sequencer
// Single-outstanding load/store sequencer between the execute stage and
// mem_interface. A request is accepted over a valid/ready handshake, held
// stable on the mem_* outputs while the bus is driven, and answered with one
// registered response (load data or error code) over a second handshake.
// Flush aborts the outstanding request; a grant timeout bounds the wait in
// ISSUE.

module lsu_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SIZE_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    // request handshake from the execute stage
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [SIZE_WIDTH-1:0] req_sign_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    // abort of the outstanding request
    input  logic                  flush,

    // response handshake back to the execute stage
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_error,

    // mem_interface side
    input  logic                  mem_available,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [SIZE_WIDTH-1:0] mem_sign_size,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_malign,
    input  logic                  mem_complete_read,
    input  logic                  mem_complete_write
);

    // Timeout counter is wide enough to hold TIMEOUT_CYCLES; a zero limit
    // turns the timeout off but still leaves a 1-bit counter in place.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for a request
        S_ISSUE,  // strobe on the bus, waiting for grant / completion
        S_WAIT,   // load issued, waiting for read data
        S_DROP,   // flushed load, swallowing its read completion
        S_RESP    // response presented, waiting for rsp_ready
    } state_t;

    state_t                  state;

    // Latched request fields, stable for the whole transaction
    logic                    op_write;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [SIZE_WIDTH-1:0]   op_size;
    logic [DATA_WIDTH-1:0]   op_wdata;

    logic [CNT_WIDTH-1:0]    tmo_cnt;
    logic                    accept;
    logic                    timeout_hit;

    // A new request can be taken when idle, or in RESP in the very cycle the
    // current response is consumed; flush and reset always block acceptance.
    assign req_ready = !rst && !flush &&
                       ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    assign timeout_hit = TIMEOUT_EN && (tmo_cnt == CNT_LIMIT);

    // Strobes and response-valid are decoded from state and forced low while
    // reset is asserted, so nothing reaches the bus during a mid-flight reset.
    assign mem_rd    = !rst && (state == S_ISSUE) && !op_write;
    assign mem_wr    = !rst && (state == S_ISSUE) &&  op_write;
    assign rsp_valid = !rst && (state == S_RESP);

    assign mem_address   = op_addr;
    assign mem_sign_size = op_size;
    assign mem_data_in   = op_wdata;

    // Capture the request fields on every accepted handshake.
    // NOTE: pure datapath registers qualified by accept need no reset; nothing
    // observes them before the first accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= req_write;
            op_addr  <= req_address;
            op_size  <= req_sign_size;
            op_wdata <= req_wdata;
        end
    end

    // Sequencer FSM with timeout counter and registered response fields.
    // NOTE: all state here is updated with non-blocking assignments so every
    // branch sees the pre-edge values of state, tmo_cnt and the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            rsp_rdata <= '0;
            rsp_error <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_ISSUE;
                        tmo_cnt <= '0;
                    end
                end

                S_ISSUE: begin
                    // Count consecutive no-grant cycles, saturating
                    if (!mem_available && (tmo_cnt != CNT_MAX)) begin
                        tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
                    end

                    if (flush) begin
                        state <= S_IDLE;
                    end else if (mem_malign) begin
                        state     <= S_RESP;
                        rsp_error <= ERR_MISALIGN;
                        rsp_rdata <= '0;
                    end else if (op_write && mem_complete_write) begin
                        state     <= S_RESP;
                        rsp_error <= ERR_OK;
                        rsp_rdata <= '0;
                    end else if (!op_write && mem_available) begin
                        // Read is on the bus this cycle; leaving ISSUE drops
                        // mem_rd so the load is issued exactly once.
                        state <= S_WAIT;
                    end else if (timeout_hit) begin
                        state     <= S_RESP;
                        rsp_error <= ERR_TIMEOUT;
                        rsp_rdata <= '0;
                    end
                end

                S_WAIT: begin
                    if (flush) begin
                        // If the data lands in the flush cycle there is
                        // nothing left to drain, so skip DROP.
                        state <= mem_complete_read ? S_IDLE : S_DROP;
                    end else if (mem_complete_read) begin
                        state     <= S_RESP;
                        rsp_error <= ERR_OK;
                        rsp_rdata <= mem_data_out;
                    end
                end

                S_DROP: begin
                    if (mem_complete_read) begin
                        state <= S_IDLE;
                    end
                end

                S_RESP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (rsp_ready) begin
                        if (accept) begin
                            state   <= S_ISSUE;
                            tmo_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Testbench for lsu_sequencer: directed vector table, hand-written corner
// sequences and a randomized phase scored against a transaction-level model.

module tb_lsu_sequencer;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 3;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [SW-1:0] req_sign_size = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          flush = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_error;
    logic          mem_available = 1'b0;
    logic [AW-1:0] mem_address;
    logic [SW-1:0] mem_sign_size;
    logic [DW-1:0] mem_data_in;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_data_out = '0;
    logic          mem_malign = 1'b0;
    logic          mem_complete_read = 1'b0;
    logic          mem_complete_write = 1'b0;

    lsu_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_sign_size(req_sign_size), .req_wdata(req_wdata),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_available(mem_available), .mem_address(mem_address), .mem_sign_size(mem_sign_size),
        .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
        .mem_malign(mem_malign), .mem_complete_read(mem_complete_read),
        .mem_complete_write(mem_complete_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bus model ----------------
    // Per-request bus behaviour, chosen by the stimulus alongside the request
    logic          nxt_malign = 1'b0;
    int            nxt_delay  = 0;     // strobe cycles before grant
    int            nxt_lat    = 0;     // extra cycles from grant+1 to read data
    logic [DW-1:0] nxt_data   = '0;

    // Behaviour of the request actually accepted by the DUT
    logic          act_write  = 1'b0;
    logic [AW-1:0] act_addr   = '0;
    logic [SW-1:0] act_size   = '0;
    logic [DW-1:0] act_wdata  = '0;
    logic          act_malign = 1'b0;
    int            act_delay  = 0;
    int            act_lat    = 0;
    logic [DW-1:0] act_data   = '0;

    bit            acc_seen   = 1'b0;
    int            issue_age  = 0;
    int            rd_cd      = -1;
    int            grants     = 0;
    logic [DW-1:0] rd_data_q  = '0;
    logic          strobe;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            rd_cd              = -1;
            issue_age          = 0;
            grants             = 0;
            mem_available      = 1'b0;
            mem_malign         = 1'b0;
            mem_complete_read  = 1'b0;
            mem_complete_write = 1'b0;
            mem_data_out       = '0;
        end else begin
            if (acc_seen) begin
                act_write  = req_write;
                act_addr   = req_address;
                act_size   = req_sign_size;
                act_wdata  = req_wdata;
                act_malign = nxt_malign;
                act_delay  = nxt_delay;
                act_lat    = nxt_lat;
                act_data   = nxt_data;
                grants     = 0;
            end
            mem_complete_read = 1'b0;
            mem_data_out      = $urandom;
            if (rd_cd == 0) begin
                mem_complete_read = 1'b1;
                mem_data_out      = rd_data_q;
                rd_cd             = -1;
            end else if (rd_cd > 0) begin
                rd_cd--;
            end
            strobe             = mem_rd || mem_wr;
            mem_available      = strobe ? (issue_age >= act_delay) : 1'b1;
            mem_malign         = strobe && act_malign;
            mem_complete_write = mem_wr && mem_available && !act_malign;
            if (mem_rd && mem_available && !act_malign) begin
                grants++;
                rd_cd     = act_lat;
                rd_data_q = act_data;
            end
            issue_age = strobe ? issue_age + 1 : 0;
        end
    end

    // ---------------- transaction scoreboard ----------------
    typedef struct {
        logic [1:0]    err;
        logic [DW-1:0] rdata;
        int            reads;
    } exp_t;

    exp_t          exp_q[$];
    bit            hold_prev = 1'b0;
    logic [DW-1:0] prev_rdata = '0;
    logic [1:0]    prev_err = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_rd || mem_wr) begin
                check("strobe_addr", mem_address, act_addr);
                check("strobe_size", 32'(mem_sign_size), 32'(act_size));
                check("strobe_dir", 32'(mem_wr), 32'(act_write));
                if (mem_wr) check("store_data", mem_data_in, act_wdata);
            end
            if (hold_prev && rsp_valid) begin
                check("hold_rdata", rsp_rdata, prev_rdata);
                check("hold_error", 32'(rsp_error), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready && !flush) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_error", 32'(rsp_error), 32'(e.err));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("bus_reads", grants, e.reads);
                end
            end
            if (req_valid && req_ready) begin
                // Outcome from the rules: misalign first, then grant never
                // within TMO no-grant cycles means timeout, else success.
                e.err   = nxt_malign ? 2'b01 : ((nxt_delay > TMO) ? 2'b10 : 2'b00);
                e.rdata = (!req_write && e.err == 2'b00) ? nxt_data : '0;
                e.reads = (!req_write && e.err == 2'b00) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
        hold_prev  = rsp_valid && !rsp_ready;
        prev_rdata = rsp_rdata;
        prev_err   = rsp_error;
        acc_seen   = req_valid && req_ready;
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [SW-1:0] size;
        logic [DW-1:0] wdata;
        logic          malign;
        logic [DW-1:0] bus_data;
        logic [1:0]    exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
        int            exp_ops;
    } vec_t;

    vec_t vecs[6];

    task automatic set_req(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s,
                           input logic [DW-1:0] wd, input logic mal, input int dly,
                           input int lat, input logic [DW-1:0] bd);
        req_write     = w;
        req_address   = a;
        req_sign_size = s;
        req_wdata     = wd;
        nxt_malign    = mal;
        nxt_delay     = dly;
        nxt_lat       = lat;
        nxt_data      = bd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  lat;
        int  ops;
        int  waited;
        bit  got;
        bit  seen;
        logic rd_before;
        int  nreq;
        bit  have;

        vecs[0] = '{1'b0, 32'h0000_0100, 3'b010, 32'h0,         1'b0, 32'h8000_00F0, 2'b00, 32'h8000_00F0, 3, 1};
        vecs[1] = '{1'b1, 32'h0000_0104, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h1111_1111, 2'b00, 32'h0,         2, 1};
        vecs[2] = '{1'b0, 32'h0000_0101, 3'b001, 32'h0,         1'b1, 32'h2222_2222, 2'b01, 32'h0,         2, 0};
        vecs[3] = '{1'b1, 32'h0000_00FF, 3'b000, 32'h0000_00AB, 1'b0, 32'h3333_3333, 2'b00, 32'h0,         2, 1};
        vecs[4] = '{1'b0, 32'h0000_0203, 3'b100, 32'h0,         1'b0, 32'h0000_00C3, 2'b00, 32'h0000_00C3, 3, 1};
        vecs[5] = '{1'b1, 32'h0000_0102, 3'b010, 32'h5555_5555, 1'b1, 32'h4444_4444, 2'b01, 32'h0,         2, 0};

        // Reset state
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_strobes", 32'({mem_rd, mem_wr}), 32'd0);

        // Table-driven single transactions, grant immediately, rsp_ready high
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            set_req(vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                    vecs[i].malign, 0, 0, vecs[i].bus_data);
            req_valid = 1'b1;
            rsp_ready = 1'b1;
            @(negedge clk);
            check("vec_accept", 32'(req_ready), 32'd1);
            ops = 0;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                next_cycle();
                req_valid = 1'b0;
                lat++;
                @(negedge clk);
                if ((mem_rd || mem_wr) && mem_available && !mem_malign) ops++;
                if (rsp_valid) begin
                    got = 1'b1;
                    check("vec_error", 32'(rsp_error), 32'(vecs[i].exp_err));
                    check("vec_rdata", rsp_rdata, vecs[i].exp_rdata);
                end
            end
            check("vec_latency", lat, vecs[i].exp_lat);
            check("vec_bus_ops", ops, vecs[i].exp_ops);
        end

        // Grant timeout: mem_available never rises for this request
        next_cycle();
        set_req(1'b0, 32'h300, 3'b010, 32'h0, 1'b0, 100, 0, 32'h0);
        req_valid = 1'b1;
        @(negedge clk);
        check("tmo_accept", 32'(req_ready), 32'd1);
        lat = 0;
        got = 1'b0;
        rd_before = 1'b0;
        while (!got && lat < 20) begin
            next_cycle();
            req_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                check("tmo_error", 32'(rsp_error), 32'd2);
                check("tmo_rdata", rsp_rdata, 32'd0);
                check("tmo_rd_drop", 32'(mem_rd), 32'd0);
            end else begin
                rd_before = mem_rd;
            end
        end
        check("tmo_latency", lat, TMO + 2);
        check("tmo_rd_held", 32'(rd_before), 32'd1);

        // Flush while waiting for read data: DROP swallows the completion
        next_cycle();
        set_req(1'b0, 32'h600, 3'b010, 32'h0, 1'b0, 0, 3, 32'h0000_0077);
        req_valid = 1'b1;
        @(negedge clk);
        check("fw_accept", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("fw_issue_rd", 32'(mem_rd), 32'd1);
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        exp_q.delete();
        set_req(1'b1, 32'h604, 3'b010, 32'h0BAD_F00D, 1'b0, 0, 0, 32'h0);
        req_valid = 1'b1;
        waited = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            if (req_ready || waited > 20) break;
            waited++;
            next_cycle();
        end
        check("fw_drop_cycles", waited, 3);
        check("fw_no_rsp", 32'(seen), 32'd0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            next_cycle();
            req_valid = 1'b0;
            lat++;
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                check("fw_next_error", 32'(rsp_error), 32'd0);
            end
        end
        check("fw_next_latency", lat, 2);

        // Response backpressure, then accept in the consuming cycle
        next_cycle();
        set_req(1'b0, 32'h400, 3'b010, 32'h0, 1'b0, 0, 0, 32'h5A5A_1234);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_accept", 32'(req_ready), 32'd1);
        next_cycle();
        set_req(1'b1, 32'h500, 3'b010, 32'hCAFE_0001, 1'b0, 0, 0, 32'h0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'h5A5A_1234);
            check("bp_error", 32'(rsp_error), 32'd0);
            check("bp_not_ready", 32'(req_ready), 32'd0);
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_same_cycle", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_issue_next", 32'(mem_wr), 32'd1);
        repeat (3) next_cycle();

        // Flush in RESP: response dropped, no accept that cycle
        set_req(1'b1, 32'h700, 3'b010, 32'h1, 1'b0, 0, 0, 32'h0);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("fr_accept", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        flush = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b0, 32'h704, 3'b010, 32'h0, 1'b0, 0, 0, 32'h0);
        req_valid = 1'b1;
        @(negedge clk);
        check("fr_valid_before", 32'(rsp_valid), 32'd1);
        check("fr_no_accept", 32'(req_ready), 32'd0);
        next_cycle();
        flush = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("fr_dropped", 32'(rsp_valid), 32'd0);
        check("fr_idle_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of ISSUE
        next_cycle();
        set_req(1'b0, 32'h800, 3'b010, 32'h0, 1'b0, 100, 0, 32'h0);
        req_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_accept", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_pre_rd", 32'(mem_rd), 32'd1);
        next_cycle();
        rst = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_rd_gated", 32'(mem_rd), 32'd0);
        check("rst_mid_ready_gated", 32'(req_ready), 32'd0);
        check("rst_mid_rsp_gated", 32'(rsp_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_idle", 32'(req_ready), 32'd1);
        check("rst_mid_rd_off", 32'(mem_rd), 32'd0);
        check("rst_mid_error_clr", 32'(rsp_error), 32'd0);

        // Randomized traffic scored by the transaction model
        nreq = 0;
        have = 1'b0;
        for (int cyc = 0; cyc < 8000 && nreq < 400; cyc++) begin
            next_cycle();
            if (!have) begin
                if ($urandom_range(3) != 0) begin
                    set_req(1'($urandom_range(1)), $urandom, 3'($urandom_range(7)), $urandom,
                            ($urandom_range(7) == 0), $urandom_range(6), $urandom_range(3),
                            $urandom);
                    req_valid = 1'b1;
                    have = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            if (req_valid && req_ready) begin
                have = 1'b0;
                nreq++;
            end
        end
        next_cycle();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (40) next_cycle();
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
